// File: rtl/logic_unit_multicycle.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR on WIDTH-bit operands, CHUNK bits per cycle.
// Optional macro LOGIC_UNIT_PARITY_EN adds a Parity output (^Result).
module logic_unit_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             Parity
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_t;

  state_t           state, next_state;
  op_t              op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CW-1:0]    count;
  logic             accept;
  logic [CHUNK-1:0] a_slice, b_slice, slice_res;

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept     = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) next_state = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Select the operand slice addressed by the chunk counter.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (count == CW'(i)) begin
        a_slice = a_reg[i*CHUNK +: CHUNK];
        b_slice = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    slice_res = '0;
    case (op_reg)
      OP_AND:  slice_res = a_slice & b_slice;
      OP_OR:   slice_res = a_slice | b_slice;
      OP_XOR:  slice_res = a_slice ^ b_slice;
      OP_NOR:  slice_res = ~(a_slice | b_slice);
      default: slice_res = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= OP_AND;
      count  <= '0;
      Result <= '0;
    end else if (accept) begin
      a_reg  <= A;
      b_reg  <= B;
      op_reg <= op_t'(op);
      count  <= '0;
      Result <= '0;
    end else if (state == S_RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (count == CW'(i)) Result[i*CHUNK +: CHUNK] <= slice_res;
      end
      // Counter saturates at the last slice; the FSM leaves RUN on that cycle.
      if (count != LAST) count <= count + 1'b1;
    end
  end

  assign Zero = ~|Result;

`ifdef LOGIC_UNIT_PARITY_EN
  assign Parity = ^Result;
`endif

endmodule

// File: tb/tb_logic_unit_multicycle.sv
// Self-checking bench for logic_unit_multicycle: table-driven ops plus handshake, reset and wide-chunk sequences.
module tb_logic_unit_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        w_start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] result;
  logic        w_busy, w_done, w_zero;
  logic [31:0] w_result;
`ifdef LOGIC_UNIT_PARITY_EN
  logic        parity, w_parity;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  logic_unit_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .Result(result), .Zero(zero)
`ifdef LOGIC_UNIT_PARITY_EN
    , .Parity(parity)
`endif
  );

  logic_unit_multicycle #(.WIDTH(32), .CHUNK(32)) u_wide (
    .clk(clk), .reset(reset), .start(w_start), .op(op), .A(a), .B(b),
    .busy(w_busy), .done(w_done), .Result(w_result), .Zero(w_zero)
`ifdef LOGIC_UNIT_PARITY_EN
    , .Parity(w_parity)
`endif
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done on the narrow unit; lat counts negedges since the accept edge.
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issues one op, checks latency, result and flags, and that the unit returns to idle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] er, input logic ez);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, {31'b0, busy}, 32'd1);
    wait_done(1, lat);
    check({name, " latency"}, lat, 32'd5);
    check({name, " result"}, result, er);
    check({name, " zero"}, {31'b0, zero}, {31'b0, ez});
    @(negedge clk);
    check({name, " idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat, ndone, last_done;

    vecs[0] = '{"xor_mix",   2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[1] = '{"xor_same",  2'b10, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    vecs[2] = '{"and_zero",  2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{"or_zero",   2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[4] = '{"nor_zero",  2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{"and_mask",  2'b00, 32'hFFFFFFFF, 32'h00FF00FF, 32'h00FF00FF, 1'b0};
    vecs[6] = '{"nor_mix",   2'b11, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h50505050, 1'b0};
    vecs[7] = '{"or_halves", 2'b01, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", {31'b0, zero}, 32'd1);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_result, vecs[i].exp_zero);

    // Unprocessed slices read 0 during RUN, then fill low slice first
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("run slice0 pending", result, 32'h00000000);
    @(negedge clk);
    check("run slice0 written", result, 32'h000000FF);
    wait_done(2, lat);
    check("partial final", result, 32'hFFFFFFFF);
    @(negedge clk);

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'h00FF00FF;
    @(negedge clk);
    op = 2'b01; a = 32'h12345678; b = 32'h87654321;
    ndone = 0;
    for (int c = 0; c < 12 && busy; c++) begin
      if (done) begin
        ndone++;
        check("busy-start result", result, 32'h00FF00FF);
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("busy-start done count", ndone, 32'd1);
    check("busy-start held", result, 32'h00FF00FF);

    // Reset in the 2nd RUN cycle aborts the op
    start = 1'b1; op = 2'b01; a = 32'hF0F0F0F0; b = 32'h0F0F0F0F;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort zero", {31'b0, zero}, 32'd1);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no done", ndone, 32'd0);
    run_op("after_abort", 2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);

    // Held start: back-to-back ops every NCHUNK+2 cycles
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h1; b = 32'h0;
    ndone = 0; last_done = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("held result", result, 32'h00000001);
        if (last_done < 0) check("held first latency", c, 32'd5);
        else               check("held spacing", c - last_done, 32'd6);
        last_done = c;
      end
    end
    check("held done count", ndone, 32'd5);
    start = 1'b0;
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    check("held drained", {31'b0, busy}, 32'd0);

    // Single-chunk configuration: done two cycles after accept
    @(negedge clk);
    w_start = 1'b1; op = 2'b10; a = 32'hDEADBEEF; b = 32'hFFFFFFFF;
    @(negedge clk);
    w_start = 1'b0;
    lat = 1;
    while (!w_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("wide latency", lat, 32'd2);
    check("wide result", w_result, 32'h21524110);
    check("wide zero", {31'b0, w_zero}, 32'd0);

`ifdef LOGIC_UNIT_PARITY_EN
    run_op("par_7", 2'b10, 32'h00000007, 32'h0, 32'h00000007, 1'b0);
    check("parity odd", {31'b0, parity}, 32'd1);
    run_op("par_3", 2'b10, 32'h00000003, 32'h0, 32'h00000003, 1'b0);
    check("parity even", {31'b0, parity}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
